// File: rtl/io_pkg.sv
// Shared definitions for the IO register block: register selects, status layout, TX FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package io_pkg;

  // One-hot register select bits within the word address IO_mem_addr[15:2]
  localparam int IO_LEDS_BIT        = 0;
  localparam int IO_UART_DATA_BIT   = 1;
  localparam int IO_UART_STATUS_BIT = 2;

  // UART_STATUS bit positions
  localparam int ST_EMPTY_BIT      = 0;
  localparam int ST_FULL_BIT       = 1;
  localparam int ST_ACTIVE_BIT     = 2;
  localparam int ST_OVF_BIT        = 3;
  localparam int ST_FULL_ALIAS_BIT = 9;  // same as ST_FULL_BIT, placed where polling loops expect it

  // Transmit framing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head-of-queue read data.
// Latency: a pushed entry is visible on pop_dat / empty the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; the caller gates on full/empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the registered count, so they reflect the state at cycle start
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // Storage array; contents need no reset because count qualifies them
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped IO block: LED register plus a FIFO-buffered 8N1 UART transmitter.
// Latency: a byte written into an empty FIFO while idle starts its start bit one edge later.
// Backpressure: none toward the core; writes to a full FIFO are dropped and flagged as sticky overflow.
module io_uart_tx
  import io_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IO_mem_addr,
  input  logic [31:0] IO_mem_wdata,
  input  logic        IO_mem_wr,
  output logic [31:0] IO_mem_rdata,
  output logic [5:0]  LEDS,
  output logic        uart_tx
);

  localparam int            DIV      = CLK_FREQ_HZ / BAUD;
  localparam int            CW       = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam int            FW       = $clog2(FIFO_DEPTH);

  logic [13:0]   word_addr;
  logic          sel_leds;
  logic          sel_data;
  logic          sel_status;
  logic          wr_ok;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dat;
  logic [FW:0]   fifo_count;

  logic          overflow;
  logic          ovf_set;
  logic          ovf_clr;
  logic [31:0]   status_word;

  tx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tx_active;
  logic          bit_done;

  logic          unused_bits;

  assign word_addr  = IO_mem_addr[15:2];
  assign sel_leds   = word_addr[IO_LEDS_BIT];
  assign sel_data   = word_addr[IO_UART_DATA_BIT];
  assign sel_status = word_addr[IO_UART_STATUS_BIT];

  // A store during reset must leave no trace
  assign wr_ok     = IO_mem_wr && !reset;
  assign fifo_push = wr_ok && sel_data && !fifo_full;
  assign ovf_set   = wr_ok && sel_data && fifo_full;
  assign ovf_clr   = wr_ok && sel_status && IO_mem_wdata[ST_OVF_BIT];

  assign tx_active = (state != IDLE);
  assign bit_done  = (cnt == CNT_LAST);

  // Pop when idle with data waiting, or at the end of a stop bit so frames run back to back
  assign fifo_pop = !reset && !fifo_empty &&
                    ((state == IDLE) || ((state == STOP) && bit_done));

  assign unused_bits = ^{IO_mem_addr[31:16], IO_mem_addr[1:0], word_addr[13:3],
                         IO_mem_wdata[31:8], fifo_count};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (IO_mem_wdata[7:0]),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Assemble the status word from live FIFO/FSM state
  always_comb begin
    status_word                    = '0;
    status_word[ST_EMPTY_BIT]      = fifo_empty;
    status_word[ST_FULL_BIT]       = fifo_full;
    status_word[ST_ACTIVE_BIT]     = tx_active;
    status_word[ST_OVF_BIT]        = overflow;
    status_word[ST_FULL_ALIAS_BIT] = fifo_full;
  end

  // Side-effect-free read mux: OR of every selected register, UART_DATA reads as zero
  always_comb begin
    IO_mem_rdata = '0;
    if (sel_leds) begin
      IO_mem_rdata = IO_mem_rdata | {26'b0, LEDS};
    end
    if (sel_status) begin
      IO_mem_rdata = IO_mem_rdata | status_word;
    end
  end

  // LED register
  always_ff @(posedge clk) begin
    if (reset) begin
      LEDS <= '0;
    end else if (wr_ok && sel_leds) begin
      LEDS <= IO_mem_wdata[5:0];
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // Transmit FSM: start bit, 8 data bits LSB first, stop bit, each DIV cycles wide
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!fifo_empty) begin
            shift   <= fifo_dat;
            state   <= START;
            uart_tx <= 1'b0;
          end else begin
            uart_tx <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= DATA;
            uart_tx <= shift[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= {1'b0, shift[7:1]};
              uart_tx <= shift[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            cnt <= '0;
            if (!fifo_empty) begin
              shift   <= fifo_dat;
              state   <= START;
              uart_tx <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: register vector table, exact serial waveform, FIFO overflow, back-to-back, reset abort.
// Latency: n/a.
// Backpressure: n/a.
module tb_io_uart_tx;

  logic        clk;
  logic        reset;
  logic [31:0] IO_mem_addr;
  logic [31:0] IO_mem_wdata;
  logic        IO_mem_wr;
  logic [31:0] IO_mem_rdata;
  logic [5:0]  LEDS;
  logic        uart_tx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] sb[$];
  int         start_times[$];

  io_uart_tx #(
    .CLK_FREQ_HZ (400),
    .BAUD        (100),
    .FIFO_DEPTH  (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .IO_mem_addr  (IO_mem_addr),
    .IO_mem_wdata (IO_mem_wdata),
    .IO_mem_wr    (IO_mem_wr),
    .IO_mem_rdata (IO_mem_rdata),
    .LEDS         (LEDS),
    .uart_tx      (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Serial monitor: decodes frames mid-bit on the falling clock edge, compares against scoreboard
  logic [7:0] mon_byte;
  int         mon_cnt  = 0;
  bit         mon_busy = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (uart_tx === 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
        start_times.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 2) begin
        check("start_bit", 32'(uart_tx), 32'h0);
      end else if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % 4) == 2) begin
        mon_byte[3'((mon_cnt - 6) / 4)] = uart_tx;
      end else if (mon_cnt == 38) begin
        check("stop_bit", 32'(uart_tx), 32'h1);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got byte 0x%02h expected no frame", mon_byte);
        end else begin
          check("frame_byte", 32'(mon_byte), 32'(sb.pop_front()));
        end
      end else if (mon_cnt == 39) begin
        mon_busy = 1'b0;
      end
    end
  end

  // Write sampled at the next edge; returns 1 time unit after that edge
  task automatic io_write(input logic [31:0] addr, input logic [31:0] data);
    IO_mem_addr  = addr;
    IO_mem_wdata = data;
    IO_mem_wr    = 1'b1;
    @(posedge clk);
    #1;
    IO_mem_wr = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n;
    n = 0;
    IO_mem_addr = 32'h10;
    IO_mem_wr   = 1'b0;
    #1;
    while (n < max_cyc && !(sb.size() == 0 && !mon_busy && IO_mem_rdata == 32'h1)) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL %s_timeout: got %0d cycles expected fewer than %0d", name, n, max_cyc);
    end
    check({name, "_status"}, IO_mem_rdata, 32'h1);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [5:0]  exp_leds;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       e;
    int         bad;

    vecs[0] = '{1'b1, 32'h0000_0004, 32'h0000_002A, 32'h0000_0000, 6'h2A};
    vecs[1] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 32'h0000_002A, 6'h2A};
    vecs[2] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0001, 6'h2A};
    vecs[3] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 32'h0000_0000, 6'h2A};
    vecs[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 6'h2A};
    vecs[5] = '{1'b0, 32'h0000_0014, 32'h0000_0000, 32'h0000_002B, 6'h2A};
    vecs[6] = '{1'b1, 32'hFFFF_0004, 32'hFFFF_FFC5, 32'h0000_002A, 6'h05};
    vecs[7] = '{1'b1, 32'h0000_0020, 32'h0000_003F, 32'h0000_0000, 6'h05};
    vecs[8] = '{1'b1, 32'h0000_0014, 32'h0000_003F, 32'h0000_0005, 6'h3F};
    vecs[9] = '{1'b0, 32'h0000_001C, 32'h0000_0000, 32'h0000_003F, 6'h3F};

    // Reset with a write pending: the write must be ignored
    reset        = 1'b1;
    IO_mem_addr  = 32'h0000_000C;
    IO_mem_wdata = 32'h0000_003F;
    IO_mem_wr    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    IO_mem_wr   = 1'b0;
    IO_mem_addr = 32'h10;
    #1;
    check("rst_uart_tx", 32'(uart_tx), 32'h1);
    check("rst_leds", 32'(LEDS), 32'h0);
    check("rst_status", IO_mem_rdata, 32'h1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Register access table
    for (int i = 0; i < 10; i++) begin
      IO_mem_addr  = vecs[i].addr;
      IO_mem_wdata = vecs[i].wdata;
      IO_mem_wr    = vecs[i].wr;
      #1;
      check($sformatf("vec%0d_rdata", i), IO_mem_rdata, vecs[i].exp_rdata);
      @(posedge clk);
      #1;
      IO_mem_wr = 1'b0;
      check($sformatf("vec%0d_leds", i), 32'(LEDS), 32'(vecs[i].exp_leds));
    end

    // Exact waveform of a single 0x55 frame
    b = 8'h55;
    sb.push_back(b);
    io_write(32'h8, 32'(b));
    IO_mem_addr = 32'h10;
    check("pre_start_tx", 32'(uart_tx), 32'h1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (i < 4) e = 1'b0;
      else if (i < 36) e = b[(i - 4) / 4];
      else e = 1'b1;
      check($sformatf("wave_%0d", i), 32'(uart_tx), 32'(e));
      if (i == 39) check("active_at_40", IO_mem_rdata, 32'h5);
    end
    @(posedge clk);
    #1;
    check("idle_tx_41", 32'(uart_tx), 32'h1);
    check("inactive_at_41", IO_mem_rdata, 32'h1);
    wait_idle("frame55", 100);

    // 18 back-to-back writes: one popped, 16 queued, last dropped
    for (int i = 0; i < 18; i++) begin
      if (i < 17) sb.push_back(8'(8'h10 + i));
      io_write(32'h8, 32'(8'h10 + i));
    end
    IO_mem_addr = 32'h10;
    #1;
    check("full_ovf_status", IO_mem_rdata, 32'h20E);
    io_write(32'h10, 32'h8);
    #1;
    check("ovf_cleared", IO_mem_rdata, 32'h206);
    io_write(32'h18, 32'h8);
    IO_mem_addr = 32'h10;
    #1;
    check("ovf_set_wins", IO_mem_rdata, 32'h20E);
    io_write(32'h10, 32'h8);
    #1;
    check("ovf_cleared2", IO_mem_rdata, 32'h206);
    wait_idle("burst", 1200);

    // Back-to-back frames have no idle gap
    start_times.delete();
    sb.push_back(8'hA5);
    sb.push_back(8'h3C);
    io_write(32'h8, 32'hA5);
    io_write(32'h8, 32'h3C);
    wait_idle("b2b", 200);
    check("b2b_frames", 32'(start_times.size()), 32'd2);
    if (start_times.size() == 2) check("b2b_gap", 32'(start_times[1] - start_times[0]), 32'd40);

    // Reset during data bit 3 with three bytes queued
    io_write(32'h8, 32'hF0);
    io_write(32'h8, 32'h11);
    io_write(32'h8, 32'h22);
    io_write(32'h8, 32'h33);
    IO_mem_addr = 32'h10;
    repeat (15) @(posedge clk);
    #1;
    check("bit3_low", 32'(uart_tx), 32'h0);
    check("bit3_status", IO_mem_rdata, 32'h4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_tx", 32'(uart_tx), 32'h1);
    check("abort_leds", 32'(LEDS), 32'h0);
    check("abort_status", IO_mem_rdata, 32'h1);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (uart_tx !== 1'b1) bad++;
    end
    check("no_frames_after_abort", 32'(bad), 32'h0);
    check("status_after_abort", IO_mem_rdata, 32'h1);

    // Long read-only stretch must not disturb any state
    io_write(32'h4, 32'h15);
    for (int i = 0; i < 100; i++) begin
      case (i % 3)
        0: IO_mem_addr = 32'h10;
        1: IO_mem_addr = 32'h8;
        default: IO_mem_addr = 32'h18;
      endcase
      IO_mem_wdata = $urandom;
      IO_mem_wr    = 1'b0;
      #1;
      check($sformatf("hold_rd_%0d", i), IO_mem_rdata, ((i % 3) == 1) ? 32'h0 : 32'h1);
      @(posedge clk);
      #1;
    end
    check("hold_leds", 32'(LEDS), 32'h15);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
